// File: rtl/la_eth_mdio.sv
// Clause 22 MDIO master: serialises one PHY register read or write per command over MDC/MDIO.
// Latency: accept at T, first MDC low phase at T+1, resp_valid at T+1+(PRE+32)*2*DIV.
// Backpressure: req_ready only in IDLE; the response is held in RESP until resp_ready.
module la_eth_mdio #(
    parameter int DIV = 4,
    parameter int PRE = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [4:0]  req_phyaddr,
    input  logic [4:0]  req_regaddr,
    input  logic [15:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [15:0] resp_rdata,
    output logic        resp_err,
    output logic        busy,
    output logic        mdc,
    output logic        mdout,
    output logic        mden,
    input  logic        mdin
);

    typedef enum logic [2:0] {S_IDLE, S_PRE, S_HDR, S_TA, S_DATA, S_RESP} state_t;

    localparam logic [8:0] PH_LAST  = 9'(2 * DIV - 1);
    localparam logic [8:0] PH_RISE  = 9'(DIV);
    // Last low-phase clk: its closing edge is the MDC rising edge, where mdin is captured.
    localparam logic [8:0] PH_SMP   = 9'(DIV - 1);
    localparam logic [4:0] PRE_LAST = 5'((PRE > 0) ? PRE - 1 : 0);

    state_t      state_q, state_d;
    logic [8:0]  ph_q, ph_d;
    logic [4:0]  bcnt_q, bcnt_d;
    logic [31:0] shreg_q, shreg_d;
    logic        wr_q, wr_d;
    logic [15:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic        mdc_q, mdc_d;
    logic        mdout_q, mdout_d;
    logic        mden_q, mden_d;
    logic        resp_valid_q, resp_valid_d;
    logic        busy_q, busy_d;
    logic        bit_end;

    assign req_ready  = (state_q == S_IDLE);
    assign resp_valid = resp_valid_q;
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;
    assign busy       = busy_q;
    assign mdc        = mdc_q;
    assign mdout      = mdout_q;
    assign mden       = mden_q;

    // State and datapath registers; reset wins over everything, including mid-frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            ph_q         <= '0;
            bcnt_q       <= '0;
            shreg_q      <= '0;
            wr_q         <= 1'b0;
            rdata_q      <= '0;
            err_q        <= 1'b0;
            mdc_q        <= 1'b0;
            mdout_q      <= 1'b1;
            mden_q       <= 1'b0;
            resp_valid_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            ph_q         <= ph_d;
            bcnt_q       <= bcnt_d;
            shreg_q      <= shreg_d;
            wr_q         <= wr_d;
            rdata_q      <= rdata_d;
            err_q        <= err_d;
            mdc_q        <= mdc_d;
            mdout_q      <= mdout_d;
            mden_q       <= mden_d;
            resp_valid_q <= resp_valid_d;
            busy_q       <= busy_d;
        end
    end

    // Next state: accept, phase/bit counting, mdin capture and frame shifting.
    always_comb begin
        state_d = state_q;
        ph_d    = ph_q;
        bcnt_d  = bcnt_q;
        shreg_d = shreg_q;
        wr_d    = wr_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        bit_end = (ph_q == PH_LAST);
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    wr_d    = req_write;
                    // ST, OP, PHYAD, REGAD, TA, DATA; reads carry 1s where the PHY drives.
                    shreg_d = {2'b01, req_write ? 2'b01 : 2'b10, req_phyaddr, req_regaddr,
                               req_write ? 2'b10 : 2'b11, req_write ? req_wdata : 16'hffff};
                    rdata_d = '0;
                    err_d   = 1'b0;
                    ph_d    = '0;
                    if (PRE > 0) begin
                        state_d = S_PRE;
                        bcnt_d  = PRE_LAST;
                    end else begin
                        state_d = S_HDR;
                        bcnt_d  = 5'd13;
                    end
                end
            end
            S_RESP: begin
                if (resp_ready) state_d = S_IDLE;
            end
            default: begin
                ph_d = bit_end ? '0 : ph_q + 9'd1;
                if (ph_q == PH_SMP && !wr_q) begin
                    if (state_q == S_TA && bcnt_q == 5'd0 && mdin) err_d = 1'b1;
                    if (state_q == S_DATA) rdata_d = {rdata_q[14:0], mdin};
                end
                if (bit_end) begin
                    if (state_q != S_PRE) shreg_d = {shreg_q[30:0], 1'b0};
                    bcnt_d = bcnt_q - 5'd1;
                    if (bcnt_q == 5'd0) begin
                        case (state_q)
                            S_PRE:   begin state_d = S_HDR;  bcnt_d = 5'd13; end
                            S_HDR:   begin state_d = S_TA;   bcnt_d = 5'd1;  end
                            S_TA:    begin state_d = S_DATA; bcnt_d = 5'd15; end
                            default: begin state_d = S_RESP; bcnt_d = 5'd0;  end
                        endcase
                    end
                end
            end
        endcase
    end

    // Pin and status outputs, registered from next state so mdout/mden change only at ph=0.
    always_comb begin
        mdc_d        = (state_d inside {S_PRE, S_HDR, S_TA, S_DATA}) && (ph_d >= PH_RISE);
        mdout_d      = 1'b1;
        mden_d       = 1'b0;
        case (state_d)
            S_PRE:        mden_d = 1'b1;
            S_HDR:        begin mdout_d = shreg_d[31]; mden_d = 1'b1; end
            S_TA, S_DATA: begin mdout_d = shreg_d[31]; mden_d = wr_d; end
            default:      ;
        endcase
        resp_valid_d = (state_d == S_RESP);
        busy_d       = (state_d != S_IDLE);
    end

endmodule

// File: tb/tb_la_eth_mdio.sv
module tb_la_eth_mdio;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        sel = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_write = 1'b0;
    logic [4:0]  req_phyaddr = '0;
    logic [4:0]  req_regaddr = '0;
    logic [15:0] req_wdata = '0;
    logic        resp_ready = 1'b0;
    logic        mdin = 1'b1;

    logic a_req_valid, a_resp_ready, a_req_ready, a_resp_valid, a_resp_err, a_busy, a_mdc, a_mdout, a_mden;
    logic b_req_valid, b_resp_ready, b_req_ready, b_resp_valid, b_resp_err, b_busy, b_mdc, b_mdout, b_mden;
    logic [15:0] a_resp_rdata, b_resp_rdata;
    logic o_req_ready, o_resp_valid, o_resp_err, o_busy, o_mdc, o_mdout, o_mden;
    logic [15:0] o_resp_rdata;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    assign a_req_valid  = req_valid & ~sel;
    assign b_req_valid  = req_valid & sel;
    assign a_resp_ready = resp_ready & ~sel;
    assign b_resp_ready = resp_ready & sel;
    assign o_req_ready  = sel ? b_req_ready  : a_req_ready;
    assign o_resp_valid = sel ? b_resp_valid : a_resp_valid;
    assign o_resp_rdata = sel ? b_resp_rdata : a_resp_rdata;
    assign o_resp_err   = sel ? b_resp_err   : a_resp_err;
    assign o_busy       = sel ? b_busy       : a_busy;
    assign o_mdc        = sel ? b_mdc        : a_mdc;
    assign o_mdout      = sel ? b_mdout      : a_mdout;
    assign o_mden       = sel ? b_mden       : a_mden;

    la_eth_mdio #(.DIV(2), .PRE(32)) u_a (
        .clk(clk), .reset(reset), .req_valid(a_req_valid), .req_ready(a_req_ready),
        .req_write(req_write), .req_phyaddr(req_phyaddr), .req_regaddr(req_regaddr),
        .req_wdata(req_wdata), .resp_valid(a_resp_valid), .resp_ready(a_resp_ready),
        .resp_rdata(a_resp_rdata), .resp_err(a_resp_err), .busy(a_busy),
        .mdc(a_mdc), .mdout(a_mdout), .mden(a_mden), .mdin(mdin));

    la_eth_mdio #(.DIV(1), .PRE(0)) u_b (
        .clk(clk), .reset(reset), .req_valid(b_req_valid), .req_ready(b_req_ready),
        .req_write(req_write), .req_phyaddr(req_phyaddr), .req_regaddr(req_regaddr),
        .req_wdata(req_wdata), .resp_valid(b_resp_valid), .resp_ready(b_resp_ready),
        .resp_rdata(b_resp_rdata), .resp_err(b_resp_err), .busy(b_busy),
        .mdc(b_mdc), .mdout(b_mdout), .mden(b_mden), .mdin(mdin));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic scramble_req();
        req_write   = 1'($urandom);
        req_phyaddr = 5'($urandom);
        req_regaddr = 5'($urandom);
        req_wdata   = 16'($urandom);
    endtask

    // Idle/reset pin state: req_ready, resp_valid, rdata, err, busy, mdc, mdout, mden.
    task automatic chk_idle(input string tag);
        chk(tag, 64'({o_req_ready, o_resp_valid, o_resp_rdata, o_resp_err, o_busy, o_mdc, o_mdout, o_mden}),
                 64'({1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0}));
    endtask

    // One full transaction on the selected instance, checked cycle by cycle against the frame model.
    task automatic run_txn(input bit wr, input logic [4:0] pa, input logic [4:0] ra,
                           input logic [15:0] wd, input logic [15:0] prd, input bit phy,
                           input int hold, input bit b2b);
        int div, pre, n, k, b, p;
        bit fb[64];
        bit en[64];
        logic [15:0] exp_rd;
        logic exp_err;
        div = sel ? 1 : 2;
        pre = sel ? 0 : 32;
        n   = pre + 32;
        k   = 0;
        for (int i = 0; i < pre; i++) begin fb[k] = 1'b1; k++; end
        fb[k] = 1'b0; k++; fb[k] = 1'b1; k++;
        fb[k] = wr ? 1'b0 : 1'b1; k++; fb[k] = wr ? 1'b1 : 1'b0; k++;
        for (int i = 4; i >= 0; i--) begin fb[k] = pa[i]; k++; end
        for (int i = 4; i >= 0; i--) begin fb[k] = ra[i]; k++; end
        fb[k] = 1'b1; k++; fb[k] = wr ? 1'b0 : 1'b1; k++;
        for (int i = 15; i >= 0; i--) begin fb[k] = wr ? wd[i] : 1'b1; k++; end
        for (int i = 0; i < n; i++) en[i] = wr || (i < pre + 14);
        exp_rd  = wr ? 16'h0000 : (phy ? prd : 16'hffff);
        exp_err = !wr && !phy;

        req_write = wr; req_phyaddr = pa; req_regaddr = ra; req_wdata = wd; req_valid = 1'b1;
        chk("req_ready_before_accept", 64'(o_req_ready), 64'(1'b1));
        step();
        req_valid = 1'b0;
        scramble_req();
        for (int j = 0; j < n * 2 * div; j++) begin
            b = j / (2 * div);
            p = j % (2 * div);
            chk($sformatf("frame j=%0d", j), 64'({o_busy, o_resp_valid, o_mdc, o_mdout, o_mden}),
                64'({1'b1, 1'b0, p >= div, fb[b], en[b]}));
            if (p == 0) begin
                if (!wr && phy && b == pre + 15)      mdin = 1'b0;
                else if (!wr && phy && b >= pre + 16) mdin = prd[15 - (b - pre - 16)];
                else                                  mdin = 1'b1;
            end
            step();
        end
        mdin = 1'b1;
        chk("resp", 64'({o_resp_valid, o_resp_err, o_resp_rdata, o_req_ready, o_mdc, o_mdout, o_mden}),
            64'({1'b1, exp_err, exp_rd, 1'b0, 1'b0, 1'b1, 1'b0}));
        for (int h = 0; h < hold; h++) begin
            if (b2b) begin
                scramble_req();
                req_valid = 1'b1;
            end
            step();
            chk("resp_hold", 64'({o_resp_valid, o_resp_err, o_resp_rdata, o_req_ready, o_busy}),
                64'({1'b1, exp_err, exp_rd, 1'b0, 1'b1}));
        end
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;
        chk("after_handshake", 64'({o_req_ready, o_resp_valid, o_busy, o_mdc, o_mden}),
            64'({1'b1, 1'b0, 1'b0, 1'b0, 1'b0}));
    endtask

    initial begin
        repeat (3) step();
        reset = 1'b0;
        sel = 1'b0; chk_idle("reset_a");
        sel = 1'b1; chk_idle("reset_b");
        sel = 1'b0;
        step();

        // Directed frames on the DIV=2, PRE=32 instance.
        run_txn(1'b1, 5'h01, 5'h00, 16'h1140, 16'h0000, 1'b0, 0, 1'b0);
        run_txn(1'b0, 5'h03, 5'h02, 16'h0000, 16'h0141, 1'b1, 0, 1'b0);
        run_txn(1'b0, 5'h07, 5'h01, 16'h0000, 16'h0000, 1'b0, 0, 1'b0);

        // Backpressure with a command waiting, then back-to-back accept.
        run_txn(1'b0, 5'($urandom), 5'($urandom), 16'h0, 16'($urandom), 1'b1, 20, 1'b1);
        run_txn(1'b1, 5'($urandom), 5'($urandom), 16'($urandom), 16'h0, 1'b0, 0, 1'b0);

        // Randomized mix.
        for (int r = 0; r < 3; r++) begin
            run_txn(1'($urandom), 5'($urandom), 5'($urandom), 16'($urandom), 16'($urandom),
                    1'b1, int'($urandom_range(0, 3)), 1'b0);
        end

        // Reset during a DATA bit while MDC is high.
        req_write = 1'b0; req_phyaddr = 5'h05; req_regaddr = 5'h11; req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        repeat ((32 + 20) * 4 + 2) step();
        chk("pre_reset_mdc_high", 64'({o_mdc, o_busy}), 64'({1'b1, 1'b1}));
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk_idle("reset_midframe");
        run_txn(1'b1, 5'($urandom), 5'($urandom), 16'($urandom), 16'h0, 1'b0, 0, 1'b0);

        // Preamble suppression on the DIV=1, PRE=0 instance.
        sel = 1'b1;
        step();
        run_txn(1'b1, 5'($urandom), 5'($urandom), 16'($urandom), 16'h0, 1'b0, 0, 1'b0);
        run_txn(1'b0, 5'($urandom), 5'($urandom), 16'h0, 16'($urandom), 1'b1, 2, 1'b0);
        run_txn(1'b0, 5'($urandom), 5'($urandom), 16'h0, 16'h0, 1'b0, 0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
